// File: rtl/systolic_output_writeback.sv
// systolic_output_writeback
//
// Captures skewed per-column results from the systolic array, deskews them into a
// ROWS x COLS buffer and then streams one full matrix row per cycle into the output
// memory. A one-cycle done pulse tells the matmul controller the result is stored.
//
// Optional feature: define WPROXY_MERGE_EN to add proxy_output_bus,
// proxy_out_valid_bus and faulty_col_mask. Columns flagged in the mask (latched on an
// accepted start) are captured from the proxy bus instead of col_data_in/col_valid_in.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, accepted only in IDLE
//   base_addr           first output row address, latched on accepted start
//   col_data_in         column c result at [c*WORD_SIZE +: WORD_SIZE]
//   col_valid_in        per-column result valid
//   mem_addr            output memory address (holds last value when idle)
//   mem_wr_en           output memory write enable
//   mem_wr_data         row data, column 0 in the LSBs, zero padded
//   busy                high whenever the FSM is not in IDLE
//   done                one-cycle completion pulse
//   overflow_err        sticky, a valid arrived on an already full column
module systolic_output_writeback #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned MEM_PORT_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [31:0]                   base_addr,
  input  logic [COLS*WORD_SIZE-1:0]     col_data_in,
  input  logic [COLS-1:0]               col_valid_in,
`ifdef WPROXY_MERGE_EN
  input  logic [COLS*WORD_SIZE-1:0]     proxy_output_bus,
  input  logic [COLS-1:0]               proxy_out_valid_bus,
  input  logic [COLS-1:0]               faulty_col_mask,
`endif
  output logic [31:0]                   mem_addr,
  output logic                          mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0]     mem_wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow_err
);

  localparam int unsigned CntW  = $clog2(ROWS + 1);
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DataW = COLS * WORD_SIZE;

  localparam logic [CntW-1:0] FullCnt = CntW'(ROWS);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [31:0]           base_q;
  logic [CntW-1:0]       col_cnt_q [COLS];
  logic [CntW-1:0]       col_cnt_d [COLS];
  logic [RowW-1:0]       wr_row_q, wr_row_d;
  logic                  overflow_q, overflow_d;
  logic [WORD_SIZE-1:0]  row_buf_q [ROWS][COLS];
  logic [31:0]           addr_hold_q;
  logic [MEM_PORT_WIDTH-1:0] data_hold_q;

  logic [DataW-1:0]      cap_data;
  logic [COLS-1:0]       cap_valid;
  logic [COLS-1:0]       cap_en;
  logic                  all_full;
  logic                  start_acc;
  logic [31:0]           cur_addr;
  logic [MEM_PORT_WIDTH-1:0] row_data;

  assign start_acc = start && (state_q == StIdle);

  // Source selection per column: proxy bus for columns flagged faulty at start.
`ifdef WPROXY_MERGE_EN
  logic [COLS-1:0] mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else if (start_acc) begin
      mask_q <= faulty_col_mask;
    end
  end

  always_comb begin
    cap_data  = col_data_in;
    cap_valid = col_valid_in;
    for (int c = 0; c < COLS; c++) begin
      if (mask_q[c]) begin
        cap_valid[c]                      = proxy_out_valid_bus[c];
        cap_data[c*WORD_SIZE +: WORD_SIZE] = proxy_output_bus[c*WORD_SIZE +: WORD_SIZE];
      end
    end
  end
`else
  assign cap_data  = col_data_in;
  assign cap_valid = col_valid_in;
`endif

  // Column counters, capture strobes and overflow detection.
  always_comb begin
    overflow_d = overflow_q;
    cap_en     = '0;
    all_full   = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      col_cnt_d[c] = col_cnt_q[c];
    end
    if (start_acc) begin
      overflow_d = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        col_cnt_d[c] = '0;
      end
    end else if (state_q == StCollect) begin
      for (int c = 0; c < COLS; c++) begin
        if (cap_valid[c]) begin
          if (col_cnt_q[c] != FullCnt) begin
            cap_en[c]    = 1'b1;
            col_cnt_d[c] = col_cnt_q[c] + CntW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
    end
    // Evaluated on next-state counts so the completing edge also moves to WRITE.
    for (int c = 0; c < COLS; c++) begin
      if (col_cnt_d[c] != FullCnt) begin
        all_full = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_row_d = wr_row_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (all_full) begin
          state_d  = StWrite;
          wr_row_d = '0;
        end
      end
      StWrite: begin
        if (wr_row_q == LastRow) begin
          state_d = StDone;
        end else begin
          wr_row_d = wr_row_q + RowW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      wr_row_q   <= '0;
      overflow_q <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        col_cnt_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_row_q   <= wr_row_d;
      overflow_q <= overflow_d;
      if (start_acc) begin
        base_q <= base_addr;
      end
      for (int c = 0; c < COLS; c++) begin
        col_cnt_q[c] <= col_cnt_d[c];
      end
    end
  end

  // Result storage; every entry is rewritten before it is read, so no reset needed.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (cap_en[c]) begin
        row_buf_q[col_cnt_q[c][RowW-1:0]][c] <= cap_data[c*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    row_data = '0;
    for (int c = 0; c < COLS; c++) begin
      row_data[c*WORD_SIZE +: WORD_SIZE] = row_buf_q[wr_row_q][c];
    end
  end

  assign cur_addr = base_q + 32'(wr_row_q);

  // Hold registers keep the memory bus stable between bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else if (state_q == StWrite) begin
      addr_hold_q <= cur_addr;
      data_hold_q <= row_data;
    end
  end

  assign mem_wr_en    = (state_q == StWrite);
  assign mem_addr     = mem_wr_en ? cur_addr : addr_hold_q;
  assign mem_wr_data  = mem_wr_en ? row_data : data_hold_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_systolic_output_writeback.sv
module tb_systolic_output_writeback;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int WS   = 16;
  localparam int MPW  = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [COLS*WS-1:0] col_data_in;
  logic [COLS-1:0]  col_valid_in;
  logic [31:0]      mem_addr;
  logic             mem_wr_en;
  logic [MPW-1:0]   mem_wr_data;
  logic             busy;
  logic             done;
  logic             overflow_err;
`ifdef WPROXY_MERGE_EN
  logic [COLS*WS-1:0] proxy_output_bus;
  logic [COLS-1:0]  proxy_out_valid_bus;
  logic [COLS-1:0]  faulty_col_mask;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  systolic_output_writeback #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .MEM_PORT_WIDTH(MPW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_addr           (base_addr),
    .col_data_in         (col_data_in),
    .col_valid_in        (col_valid_in),
`ifdef WPROXY_MERGE_EN
    .proxy_output_bus    (proxy_output_bus),
    .proxy_out_valid_bus (proxy_out_valid_bus),
    .faulty_col_mask     (faulty_col_mask),
`endif
    .mem_addr            (mem_addr),
    .mem_wr_en           (mem_wr_en),
    .mem_wr_data         (mem_wr_data),
    .busy                (busy),
    .done                (done),
    .overflow_err        (overflow_err)
  );

  typedef struct {
    logic        start;
    logic [31:0] base;
    logic [3:0]  valid;
    logic [63:0] data;
    logic        exp_wr_en;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input row r, column c carries 10*r+c; mode 1 poisons column 1 with 0xDEAD.
  function automatic logic [63:0] in_row(input int r, input int mode);
    logic [63:0] d;
    for (int c = 0; c < COLS; c++) d[c*WS +: WS] = 16'(10 * r + c);
    if (mode == 1) d[WS +: WS] = 16'hDEAD;
    return d;
  endfunction

  // Expected memory row; in mode 1 column 1 comes from the proxy when merging is built.
  function automatic logic [63:0] exp_row(input int r, input int mode);
    logic [63:0] d;
    for (int c = 0; c < COLS; c++) d[c*WS +: WS] = 16'(10 * r + c);
`ifdef WPROXY_MERGE_EN
    if (mode == 1) d[WS +: WS] = 16'(7 * r);
`else
    if (mode == 1) d[WS +: WS] = 16'hDEAD;
`endif
    return d;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [63:0] d, input int r);
    col_valid_in = v;
    col_data_in  = d;
`ifdef WPROXY_MERGE_EN
    proxy_out_valid_bus = v;
    proxy_output_bus    = {16'hFFFF, 16'hFFFF, 16'(7 * r), 16'hFFFF};
`else
    if (r < 0) col_data_in = d;
`endif
  endtask

  task automatic do_start(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  task automatic feed_rows(input int first, input int last, input int mode);
    for (int r = first; r <= last; r++) begin
      drive(4'hF, in_row(r, mode), r);
      tick();
    end
    drive(4'h0, 64'h0, 0);
  endtask

  // Called right after the edge that sampled the last valid.
  task automatic check_burst(input string name, input logic [31:0] base, input int mode);
    for (int r = 0; r < ROWS; r++) begin
      chk({name, " wr_en"}, 64'(mem_wr_en), 64'd1);
      chk({name, " addr"}, 64'(mem_addr), 64'(base + 32'(r)));
      chk({name, " data"}, mem_wr_data, exp_row(r, mode));
      tick();
    end
    chk({name, " wr_en after"}, 64'(mem_wr_en), 64'd0);
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " addr hold"}, 64'(mem_addr), 64'(base + 32'(ROWS - 1)));
    tick();
    chk({name, " done drop"}, 64'(done), 64'd0);
    chk({name, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    rst = 1'b1; start = 1'b0; base_addr = '0;
`ifdef WPROXY_MERGE_EN
    faulty_col_mask = '0;
`endif
    drive(4'h0, 64'h0, 0);
    tick(); tick();
    chk("reset outs", {mem_addr, 28'h0, mem_wr_en, busy, done, overflow_err}, 64'h0);
    chk("reset data", mem_wr_data, 64'h0);
    rst = 1'b0;
    tick();
    chk("idle after reset", 64'(busy), 64'd0);

    // Aligned capture at base 0x10.
    vecs[0] = '{1'b1, 32'h10, 4'h0, 64'h0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b0};
    for (int r = 0; r < 4; r++)
      vecs[1+r] = '{1'b0, 32'h0, 4'hF, in_row(r, 0), 1'b0, 32'h0, 64'h0, 1'b1, 1'b0};
    vecs[4].exp_wr_en = 1'b1; vecs[4].exp_addr = 32'h10;
    vecs[4].exp_wdata = 64'h0003_0002_0001_0000;
    vecs[5] = '{1'b0, 32'h0, 4'h0, 64'h0, 1'b1, 32'h11, 64'h000D_000C_000B_000A, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h0, 4'h0, 64'h0, 1'b1, 32'h12, 64'h0017_0016_0015_0014, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h0, 4'h0, 64'h0, 1'b1, 32'h13, 64'h0021_0020_001F_001E, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 32'h0, 4'h0, 64'h0, 1'b0, 32'h13, 64'h0021_0020_001F_001E, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 32'h0, 4'h0, 64'h0, 1'b0, 32'h13, 64'h0021_0020_001F_001E, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start; base_addr = vecs[i].base;
      col_valid_in = vecs[i].valid; col_data_in = vecs[i].data;
      tick();
      n_tests++;
      if ({mem_wr_en, mem_addr, mem_wr_data, busy, done} !==
          {vecs[i].exp_wr_en, vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_busy,
           vecs[i].exp_done}) begin
        n_fail++;
        $display("FAIL vec%0d: got en=%b addr=%h data=%h busy=%b done=%b expected en=%b addr=%h data=%h busy=%b done=%b",
                 i, mem_wr_en, mem_addr, mem_wr_data, busy, done, vecs[i].exp_wr_en,
                 vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_busy, vecs[i].exp_done);
      end
    end
    drive(4'h0, 64'h0, 0);

    // Skewed capture: column c starts c cycles after column 0.
    do_start(32'h10);
    for (int t = 0; t < 7; t++) begin
      d = 64'hAAAA_AAAA_AAAA_AAAA;
      col_valid_in = '0;
      for (int c = 0; c < COLS; c++) begin
        if (t >= c && t < c + ROWS) begin
          col_valid_in[c] = 1'b1;
          d[c*WS +: WS] = 16'(10 * (t - c) + c);
        end
      end
      col_data_in = d;
      tick();
      if (t == 5) chk("skew no early write", 64'(mem_wr_en), 64'd0);
    end
    drive(4'h0, 64'h0, 0);
    check_burst("skew", 32'h10, 0);

    // Overflow: fifth valid on column 2 before column 3 completes.
    do_start(32'h50);
    chk("ovf clear", 64'(overflow_err), 64'd0);
    for (int r = 0; r < 4; r++) begin
      drive(4'b0111, in_row(r, 0), r);
      tick();
    end
    drive(4'b0100, 64'h0000_BEEF_0000_0000, 0);
    tick();
    chk("ovf set", 64'(overflow_err), 64'd1);
    chk("ovf no write", 64'(mem_wr_en), 64'd0);
    for (int r = 0; r < 4; r++) begin
      drive(4'b1000, in_row(r, 0), r);
      tick();
    end
    drive(4'h0, 64'h0, 0);
    check_burst("ovf", 32'h50, 0);
    chk("ovf sticky", 64'(overflow_err), 64'd1);

    // Next start clears overflow; a start during COLLECT is ignored.
    do_start(32'h60);
    chk("ovf cleared by start", 64'(overflow_err), 64'd0);
    feed_rows(0, 1, 0);
    do_start(32'h80);
    feed_rows(2, 3, 0);
    check_burst("start busy", 32'h60, 0);

    // Reset in the middle of WRITE.
    do_start(32'h20);
    feed_rows(0, 3, 0);
    tick();
    chk("pre-reset write", 64'(mem_addr), 64'h21);
    #2 rst = 1'b1;
    #1;
    chk("rst async outs", {mem_addr, 28'h0, mem_wr_en, busy, done, overflow_err}, 64'h0);
    chk("rst async data", mem_wr_data, 64'h0);
    tick();
    chk("rst hold wr_en", 64'(mem_wr_en), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post-reset quiet", {63'h0, mem_wr_en | busy}, 64'd0);
    end
    do_start(32'h40);
    feed_rows(0, 3, 0);
    check_burst("fresh", 32'h40, 0);

    // Proxy merge on column 1 (falls back to 0xDEAD when the feature is absent).
`ifdef WPROXY_MERGE_EN
    faulty_col_mask = 4'b0010;
`endif
    do_start(32'h70);
`ifdef WPROXY_MERGE_EN
    faulty_col_mask = 4'b0000;
`endif
    feed_rows(0, 3, 1);
    check_burst("proxy", 32'h70, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
